tsl1401_line_capture: RTL and testbench

- Downstream consumer of the TSL1401 sensor sequencer, in the same clock domain.
- Watches the sequencer's SI and AD-trigger strobes. On each trigger it runs one SPI conversion on an external 12-bit serial ADC (ADCS7476-class, 16-clock frame).
- Emits one pixel word per conversion, tagged with its pixel index, plus per-line status.

---
 rtl/tsl1401_line_capture.sv | 189 ++++++++++++++++++
 tb/tb_tsl1401_line_capture.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tsl1401_line_capture.sv
`default_nettype none
// ============================================================================
// Module   : tsl1401_line_capture
// Brief    : Runs one SPI ADC conversion per sequencer AD trigger and emits
//            indexed pixel words plus per-line done/short/overrun status.
// Revision : 1.0  initial release
// ============================================================================
module tsl1401_line_capture #(
    parameter int NUM_PIXELS   = 128,
    parameter int SCLK_DIV     = 2,
    parameter int QUIET_CYCLES = 4,
    parameter int FRAME_BITS   = 16,
    parameter int ADC_BITS     = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sensor_si,
    input  logic                ad_trig,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    input  logic                adc_miso,
    output logic                pixel_valid,
    output logic [ADC_BITS-1:0] pixel_data,
    output logic [6:0]          pixel_index,
    output logic                line_done,
    output logic                line_short,
    output logic                overrun
);

    localparam logic [6:0] c_LAST_IDX   = 7'(NUM_PIXELS - 1);
    localparam logic [7:0] c_DIV_LAST   = 8'(SCLK_DIV - 1);
    localparam logic [7:0] c_QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam logic [7:0] c_BITS_LAST  = 8'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_QUIET    = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_si_d;
    logic                r_trig_d;
    logic                r_line_active;
    logic [6:0]          r_trig_count;
    logic [6:0]          r_cap_index;
    logic [7:0]          r_div_cnt;
    logic [7:0]          r_bit_cnt;
    logic [ADC_BITS-1:0] r_shift;

    logic       w_si_rise;
    logic       w_trig_rise;
    logic       w_line_active;
    logic [6:0] w_next_index;
    logic       w_accept;
    logic       w_div_done;

    // An SI rise is applied before a coincident trigger, so that trigger
    // becomes index 0 of the new line.
    assign w_si_rise     = sensor_si & ~r_si_d;
    assign w_trig_rise   = ad_trig & ~r_trig_d;
    assign w_line_active = w_si_rise | r_line_active;
    assign w_next_index  = w_si_rise ? 7'd0 : r_trig_count;
    assign w_accept      = w_trig_rise & w_line_active;
    assign w_div_done    = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_si_d        <= 1'b0;
            r_trig_d      <= 1'b0;
            r_line_active <= 1'b0;
            r_trig_count  <= '0;
            r_cap_index   <= '0;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            adc_cs_n      <= 1'b1;
            adc_sclk      <= 1'b0;
            pixel_valid   <= 1'b0;
            pixel_data    <= '0;
            pixel_index   <= '0;
            line_done     <= 1'b0;
            line_short    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            r_si_d      <= sensor_si;
            r_trig_d    <= ad_trig;
            pixel_valid <= 1'b0;
            line_done   <= 1'b0;
            line_short  <= 1'b0;

            if (w_si_rise) begin
                r_trig_count  <= '0;
                r_line_active <= 1'b1;
                overrun       <= 1'b0;
                if (r_line_active) begin
                    line_done  <= 1'b1;
                    line_short <= 1'b1;
                end
            end

            // A trigger while busy still consumes its index; only the
            // conversion is dropped.
            if (w_accept) begin
                r_trig_count <= w_next_index + 7'd1;
                if (w_next_index == c_LAST_IDX) begin
                    r_line_active <= 1'b0;
                end
                if (r_state != ST_IDLE) begin
                    overrun <= 1'b1;
                    if (w_next_index == c_LAST_IDX) begin
                        line_done <= 1'b1;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cap_index <= w_next_index;
                        adc_cs_n    <= 1'b0;
                        r_div_cnt   <= '0;
                        r_bit_cnt   <= '0;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        adc_sclk  <= 1'b1;
                        r_shift   <= {r_shift[ADC_BITS-2:0], adc_miso};
                        r_state   <= ST_SHIFT_HI;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        adc_sclk  <= 1'b0;
                        r_state   <= ST_SHIFT_LO;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_div_done) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt == c_BITS_LAST) begin
                            adc_cs_n    <= 1'b1;
                            pixel_valid <= 1'b1;
                            pixel_data  <= r_shift;
                            pixel_index <= r_cap_index;
                            if (r_cap_index == c_LAST_IDX) begin
                                line_done <= 1'b1;
                            end
                            r_state <= ST_QUIET;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                            adc_sclk  <= 1'b1;
                            r_shift   <= {r_shift[ADC_BITS-2:0], adc_miso};
                            r_state   <= ST_SHIFT_HI;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                ST_QUIET: begin
                    if (r_div_cnt == c_QUIET_LAST) begin
                        r_div_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                default: begin
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tsl1401_line_capture.sv
`default_nettype none
// Directed bench for tsl1401_line_capture with a simple serial ADC model
// that presents frame bits MSB first, advancing on each SCLK falling edge.
module tb_tsl1401_line_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sensor_si = 1'b0;
    logic        ad_trig = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_miso;
    logic        pixel_valid;
    logic [11:0] pixel_data;
    logic [6:0]  pixel_index;
    logic        line_done;
    logic        line_short;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sclk_rises = 0;
    int fall_cnt = 0;
    logic [15:0] adc_frame = 16'h0000;

    typedef struct {
        int         cyc;
        logic [6:0] idx;
        logic [11:0] data;
        logic       done;
        logic       shrt;
    } pv_t;
    typedef struct {
        int   cyc;
        logic shrt;
    } ld_t;
    pv_t pv_q[$];
    ld_t ld_q[$];

    tsl1401_line_capture dut (
        .clk        (clk),
        .reset      (reset),
        .sensor_si  (sensor_si),
        .ad_trig    (ad_trig),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_miso   (adc_miso),
        .pixel_valid(pixel_valid),
        .pixel_data (pixel_data),
        .pixel_index(pixel_index),
        .line_done  (line_done),
        .line_short (line_short),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge adc_sclk) sclk_rises <= sclk_rises + 1;

    always @(negedge adc_sclk or posedge adc_cs_n) begin
        if (adc_cs_n) fall_cnt <= 0;
        else          fall_cnt <= fall_cnt + 1;
    end
    assign adc_miso = (fall_cnt < 16) ? adc_frame[4'(15 - fall_cnt)] : 1'b0;

    always @(negedge clk) begin
        if (pixel_valid) pv_q.push_back('{cyc, pixel_index, pixel_data, line_done, line_short});
        if (line_done)   ld_q.push_back('{cyc, line_short});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_trig(output int t);
        t = cyc;
        ad_trig = 1'b1;
        tick(1);
        ad_trig = 1'b0;
    endtask

    task automatic pulse_si();
        sensor_si = 1'b1;
        tick(1);
        sensor_si = 1'b0;
    endtask

    task automatic expect_pixel(input string tag, input int idx, input logic [11:0] data,
                                input logic done, input logic shrt);
        pv_t ev;
        check({tag, "_present"}, 32'(pv_q.size() > 0), 32'd1);
        if (pv_q.size() > 0) begin
            ev = pv_q.pop_front();
            check({tag, "_idx"},   32'(ev.idx),  32'(idx));
            check({tag, "_data"},  32'(ev.data), 32'(data));
            check({tag, "_done"},  32'(ev.done), 32'(done));
            check({tag, "_short"}, 32'(ev.shrt), 32'(shrt));
        end
    endtask

    initial begin
        int t;
        int t2;
        int base;
        logic [15:0] f;

        // Reset state
        tick(3);
        check("rst_cs_n",  32'(adc_cs_n),    32'd1);
        check("rst_sclk",  32'(adc_sclk),    32'd0);
        check("rst_pv",    32'(pixel_valid), 32'd0);
        check("rst_data",  32'(pixel_data),  32'd0);
        check("rst_index", 32'(pixel_index), 32'd0);
        check("rst_done",  32'(line_done),   32'd0);
        check("rst_short", 32'(line_short),  32'd0);
        check("rst_ovr",   32'(overrun),     32'd0);
        reset = 1'b1;
        tick(3);

        // Single pixel, latency and SCLK count
        adc_frame = 16'h0ABC;
        pulse_si();
        tick(2);
        base = sclk_rises;
        pulse_trig(t);
        check("t1_cs_low", 32'(adc_cs_n), 32'd0);
        tick(70);
        check("t1_pv_count", 32'(pv_q.size()), 32'd1);
        if (pv_q.size() > 0) check("t1_latency", 32'(pv_q[0].cyc), 32'(t + 67));
        expect_pixel("t1", 0, 12'hABC, 1'b0, 1'b0);
        check("t1_sclk_rises", 32'(sclk_rises - base), 32'd16);
        check("t1_cs_high", 32'(adc_cs_n), 32'd1);
        check("t1_no_line_done", 32'(ld_q.size()), 32'd0);
        tick(10);
        check("t1_data_hold", 32'(pixel_data), 32'hABC);

        // Overrun: second trigger 30 cycles into the first conversion
        pulse_si();
        check("t2_si_done",  32'(line_done),  32'd1);
        check("t2_si_short", 32'(line_short), 32'd1);
        ld_q.delete();
        adc_frame = 16'h1234;
        pulse_trig(t);
        tick(29);
        pulse_trig(t2);
        check("t2_gap", 32'(t2 - t), 32'd30);
        check("t2_ovr_set", 32'(overrun), 32'd1);
        tick(50);
        check("t2_pv_count", 32'(pv_q.size()), 32'd1);
        expect_pixel("t2_a", 0, 12'h234, 1'b0, 1'b0);
        adc_frame = 16'hC5A7;
        pulse_trig(t);
        tick(70);
        expect_pixel("t2_c", 2, 12'h5A7, 1'b0, 1'b0);
        check("t2_ovr_sticky", 32'(overrun), 32'd1);
        tick(5);
        pulse_si();
        check("t2_ovr_clear", 32'(overrun), 32'd0);
        check("t2_short2", 32'(line_short), 32'd1);
        tick(2);
        ld_q.delete();

        // Short line: 50 triggers then SI
        for (int i = 0; i < 50; i++) begin
            f = 16'(i * 1237 + 16'h8005);
            adc_frame = f;
            pulse_trig(t);
            tick(79);
            expect_pixel("t3", i, f[11:0], 1'b0, 1'b0);
        end
        pulse_si();
        check("t3_done",  32'(line_done),  32'd1);
        check("t3_short", 32'(line_short), 32'd1);
        tick(2);
        ld_q.delete();
        adc_frame = 16'h0F00;
        pulse_trig(t);
        tick(75);
        expect_pixel("t3_next", 0, 12'hF00, 1'b0, 1'b0);

        // Simultaneous SI and trigger rise
        adc_frame = 16'h07E1;
        sensor_si = 1'b1;
        ad_trig = 1'b1;
        tick(1);
        sensor_si = 1'b0;
        ad_trig = 1'b0;
        check("t4_short", 32'(line_short), 32'd1);
        tick(75);
        expect_pixel("t4", 0, 12'h7E1, 1'b0, 1'b0);

        // Full line of NUM_PIXELS triggers
        pulse_si();
        tick(5);
        ld_q.delete();
        for (int i = 0; i < 128; i++) begin
            f = 16'($urandom);
            adc_frame = f;
            pulse_trig(t);
            tick(79);
            expect_pixel("t5", i, f[11:0], 1'(i == 127), 1'b0);
        end
        check("t5_ld_count", 32'(ld_q.size()), 32'd1);
        check("t5_ovr", 32'(overrun), 32'd0);
        // Trigger on an inactive line is ignored silently
        pulse_trig(t);
        tick(80);
        check("t5_ignored_pv", 32'(pv_q.size()), 32'd0);
        check("t5_ignored_ovr", 32'(overrun), 32'd0);

        // Reset in the middle of a conversion
        pulse_si();
        tick(2);
        adc_frame = 16'h0333;
        pulse_trig(t);
        tick(19);
        check("t6_cyc", 32'(cyc - t), 32'd20);
        check("t6_sclk_hi", 32'(adc_sclk), 32'd1);
        check("t6_cs_lo", 32'(adc_cs_n), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_async_cs", 32'(adc_cs_n), 32'd1);
        check("t6_async_sclk", 32'(adc_sclk), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(80);
        check("t6_no_pv", 32'(pv_q.size()), 32'd0);
        pulse_si();
        tick(2);
        adc_frame = 16'h9DEF;
        pulse_trig(t);
        tick(70);
        expect_pixel("t6_after", 0, 12'hDEF, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
